// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Runs one sequential multiply-accumulate (acc += data_a * data_b) for every
//   change reported by the upstream operand change detector. The multiply is a
//   DATA_W-cycle shift-add, followed by a single accumulate cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for input_changed; clear ops are handled in place
//   MULT  | shift-add, one bit of b_reg per cycle, DATA_W cycles
//   ACCUM | publish product, update acc/overflow, chain a pending op
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   data_a/data_b  unsigned operands, captured with input_changed
//   clear_mult     clear request, only meaningful together with input_changed
//   input_changed  change flag from the detector
//   product        last completed a*b
//   acc_out        accumulator, wraps mod 2^ACC_W
//   busy           high whenever not IDLE
//   done           one-cycle pulse when product/acc_out have just updated
//   overflow       sticky carry out of the accumulator since the last clear
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_a,
  input  logic [DATA_W-1:0]     data_b,
  input  logic                  clear_mult,
  input  logic                  input_changed,
  output logic [2*DATA_W-1:0]   product,
  output logic [ACC_W-1:0]      acc_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [2*DATA_W-1:0] partial;
  logic [CNT_W-1:0]    cnt;

  logic                pend_valid, pend_clr;
  logic [DATA_W-1:0]   pend_a, pend_b;

  // Control strobes from the FSM to the datapath
  logic                load_op;
  logic [DATA_W-1:0]   op_a, op_b;
  logic                do_step;
  logic                finish;
  logic                do_accum;
  logic                do_clear;
  logic                pend_set;
  logic                pend_take;

  // Operand chosen at the end of ACCUM: a fresh change beats the pending slot
  logic                nxt_valid, nxt_clr;
  logic [DATA_W-1:0]   nxt_a, nxt_b;

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] addend;
  logic [ACC_W:0]      acc_sum;

  assign a_ext   = {{DATA_W{1'b0}}, a_reg};
  assign addend  = b_reg[cnt] ? (a_ext << cnt) : '0;
  assign acc_sum = {1'b0, acc_out} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, partial};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    load_op   = 1'b0;
    op_a      = data_a;
    op_b      = data_b;
    do_step   = 1'b0;
    finish    = 1'b0;
    do_accum  = 1'b0;
    do_clear  = 1'b0;
    pend_set  = 1'b0;
    pend_take = 1'b0;
    nxt_valid = 1'b0;
    nxt_clr   = 1'b0;
    nxt_a     = data_a;
    nxt_b     = data_b;

    case (state)
      IDLE: begin
        if (input_changed) begin
          if (clear_mult) begin
            do_clear = 1'b1;
          end else begin
            load_op = 1'b1;
            state_d = MULT;
          end
        end
      end

      MULT: begin
        do_step  = 1'b1;
        pend_set = input_changed;
        if (cnt == CNT_LAST) state_d = ACCUM;
      end

      ACCUM: begin
        finish    = 1'b1;
        pend_take = 1'b1;
        if (input_changed) begin
          nxt_valid = 1'b1;
          nxt_clr   = clear_mult;
        end else if (pend_valid) begin
          nxt_valid = 1'b1;
          nxt_clr   = pend_clr;
          nxt_a     = pend_a;
          nxt_b     = pend_b;
        end

        // A queued clear replaces this accumulation; product still publishes.
        if (nxt_valid && nxt_clr) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end else if (nxt_valid) begin
          do_accum = 1'b1;
          load_op  = 1'b1;
          op_a     = nxt_a;
          op_b     = nxt_b;
          state_d  = MULT;
        end else begin
          do_accum = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      partial    <= '0;
      cnt        <= '0;
      product    <= '0;
      acc_out    <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      pend_valid <= 1'b0;
      pend_clr   <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
    end else begin
      done <= finish;

      if (load_op) begin
        a_reg   <= op_a;
        b_reg   <= op_b;
        partial <= '0;
        cnt     <= '0;
      end else if (do_step) begin
        partial <= partial + addend;
        cnt     <= cnt + CNT_W'(1);
      end

      if (finish) product <= partial;

      if (do_clear) begin
        acc_out  <= '0;
        overflow <= 1'b0;
      end else if (do_accum) begin
        acc_out  <= acc_sum[ACC_W-1:0];
        overflow <= overflow | acc_sum[ACC_W];
      end

      // Latest change wins the single pending slot.
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_clr   <= clear_mult;
        pend_a     <= data_a;
        pend_b     <= data_b;
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
//   Directed bench for mac_sequencer. dut24 uses the default ACC_W=24,
//   dut16 uses ACC_W=16 to reach accumulator overflow. Both share clock, reset
//   and operand inputs; each has its own input_changed strobe.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_a = '0;
  logic [7:0]  data_b = '0;
  logic        clear_mult = 1'b0;
  logic        ic24 = 1'b0;
  logic        ic16 = 1'b0;

  logic [15:0] product24, product16;
  logic [23:0] acc24;
  logic [15:0] acc16;
  logic        busy24, busy16, done24, done16, ovf24, ovf16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_W(8), .ACC_W(24)) dut24 (
    .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
    .clear_mult(clear_mult), .input_changed(ic24),
    .product(product24), .acc_out(acc24), .busy(busy24),
    .done(done24), .overflow(ovf24)
  );

  mac_sequencer #(.DATA_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
    .clear_mult(clear_mult), .input_changed(ic16),
    .product(product16), .acc_out(acc16), .busy(busy16),
    .done(done16), .overflow(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] prod_s(input bit sel);
    return sel ? {16'd0, product16} : {16'd0, product24};
  endfunction
  function automatic logic [31:0] acc_s(input bit sel);
    return sel ? {16'd0, acc16} : {8'd0, acc24};
  endfunction
  function automatic logic busy_s(input bit sel);
    return sel ? busy16 : busy24;
  endfunction
  function automatic logic done_s(input bit sel);
    return sel ? done16 : done24;
  endfunction
  function automatic logic ovf_s(input bit sel);
    return sel ? ovf16 : ovf24;
  endfunction

  // Hold input_changed for one cycle (cycle T); returns in cycle T+1.
  task automatic launch(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic clr);
    data_a     = a;
    data_b     = b;
    clear_mult = clr;
    if (sel) ic16 = 1'b1;
    else     ic24 = 1'b1;
    tick();
    ic16       = 1'b0;
    ic24       = 1'b0;
    clear_mult = 1'b0;
  endtask

  // Full op with exact latency: busy T+1..T+9 without done, done at T+10.
  task automatic run_op(input string tag, input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] exp_prod, input logic [31:0] exp_acc, input logic exp_ovf);
    logic window_ok;
    launch(sel, a, b, 1'b0);
    window_ok = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (!(busy_s(sel) === 1'b1 && done_s(sel) === 1'b0)) window_ok = 1'b0;
      tick();
    end
    check({tag, ".busy_window"}, {31'd0, window_ok}, 32'd1);
    check({tag, ".done"},    {31'd0, done_s(sel)}, 32'd1);
    check({tag, ".product"}, prod_s(sel), exp_prod);
    check({tag, ".acc"},     acc_s(sel),  exp_acc);
    check({tag, ".ovf"},     {31'd0, ovf_s(sel)}, {31'd0, exp_ovf});
    check({tag, ".idle"},    {31'd0, busy_s(sel)}, 32'd0);
    tick();
    check({tag, ".done_drop"}, {31'd0, done_s(sel)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("rst.product", prod_s(0), 32'd0);
    check("rst.acc",     acc_s(0),  32'd0);
    check("rst.busy",    {31'd0, busy_s(0)}, 32'd0);
    check("rst.done",    {31'd0, done_s(0)}, 32'd0);
    check("rst.ovf",     {31'd0, ovf_s(0)},  32'd0);

    // 3*5, then 255*255
    run_op("t1", 0, 8'd3,   8'd5,   32'd15,    32'd15,    1'b0);
    run_op("t2", 0, 8'd255, 8'd255, 32'd65025, 32'd65040, 1'b0);

    // clear_mult level without a change flag is ignored
    clear_mult = 1'b1;
    repeat (2) tick();
    clear_mult = 1'b0;
    check("lvl.acc",  acc_s(0), 32'd65040);
    check("lvl.busy", {31'd0, busy_s(0)}, 32'd0);

    // 16-bit accumulator overflow, then clear op
    run_op("t3a", 1, 8'd255, 8'd255, 32'd65025, 32'd65025, 1'b0);
    run_op("t3b", 1, 8'd255, 8'd255, 32'd65025, 32'd64514, 1'b1);
    launch(1, 8'd9, 8'd9, 1'b1);
    check("t3c.acc",  acc_s(1), 32'd0);
    check("t3c.ovf",  {31'd0, ovf_s(1)},  32'd0);
    check("t3c.done", {31'd0, done_s(1)}, 32'd0);
    check("t3c.busy", {31'd0, busy_s(1)}, 32'd0);
    tick();
    check("t3c.done2", {31'd0, done_s(1)}, 32'd0);

    // clear dut24, then 2*2 with 4*4 and 6*6 arriving while busy
    launch(0, 8'd0, 8'd0, 1'b1);
    check("t4.clr_acc", acc_s(0), 32'd0);
    launch(0, 8'd2, 8'd2, 1'b0);              // T+1
    tick();                                   // T+2
    data_a = 8'd4; data_b = 8'd4; ic24 = 1'b1;
    tick();                                   // T+3
    ic24 = 1'b0;
    tick();                                   // T+4
    data_a = 8'd6; data_b = 8'd6; ic24 = 1'b1;
    tick();                                   // T+5
    ic24 = 1'b0;
    repeat (5) tick();                        // T+10
    check("t4.done1", {31'd0, done_s(0)}, 32'd1);
    check("t4.prod1", prod_s(0), 32'd4);
    check("t4.acc1",  acc_s(0),  32'd4);
    check("t4.busy1", {31'd0, busy_s(0)}, 32'd1);
    repeat (9) tick();                        // T+19
    check("t4.done2", {31'd0, done_s(0)}, 32'd1);
    check("t4.prod2", prod_s(0), 32'd36);
    check("t4.acc2",  acc_s(0),  32'd40);
    check("t4.busy2", {31'd0, busy_s(0)}, 32'd0);

    // fresh change in ACCUM beats the pending 5*5
    launch(0, 8'd3, 8'd3, 1'b0);              // T+1
    repeat (2) tick();                        // T+3
    data_a = 8'd5; data_b = 8'd5; ic24 = 1'b1;
    tick();                                   // T+4
    ic24 = 1'b0;
    repeat (5) tick();                        // T+9 (ACCUM)
    data_a = 8'd7; data_b = 8'd7; ic24 = 1'b1;
    tick();                                   // T+10
    ic24 = 1'b0;
    check("fw.prod1", prod_s(0), 32'd9);
    check("fw.acc1",  acc_s(0),  32'd49);
    check("fw.busy1", {31'd0, busy_s(0)}, 32'd1);
    repeat (9) tick();                        // T+19
    check("fw.done2", {31'd0, done_s(0)}, 32'd1);
    check("fw.prod2", prod_s(0), 32'd49);
    check("fw.acc2",  acc_s(0),  32'd98);
    tick();
    check("fw.idle",  {31'd0, busy_s(0)}, 32'd0);

    // asynchronous reset in the 4th MULT cycle of 7*9
    launch(0, 8'd7, 8'd9, 1'b0);              // T+1
    repeat (3) tick();                        // T+4
    rst = 1'b1;
    #1;
    check("t5.prod", prod_s(0), 32'd0);
    check("t5.acc",  acc_s(0),  32'd0);
    check("t5.busy", {31'd0, busy_s(0)}, 32'd0);
    check("t5.done", {31'd0, done_s(0)}, 32'd0);
    check("t5.ovf",  {31'd0, ovf_s(0)},  32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_op("t5b", 0, 8'd1, 8'd1, 32'd1, 32'd1, 1'b0);

    // zero operand still takes the full latency
    run_op("zero", 0, 8'd0, 8'd200, 32'd0, 32'd1, 1'b0);

    // clear queued during 10*10
    launch(0, 8'd10, 8'd10, 1'b0);            // T+1
    tick();                                   // T+2
    data_a = 8'd3; data_b = 8'd3; clear_mult = 1'b1; ic24 = 1'b1;
    tick();                                   // T+3
    ic24 = 1'b0; clear_mult = 1'b0;
    repeat (7) tick();                        // T+10
    check("t6.done", {31'd0, done_s(0)}, 32'd1);
    check("t6.prod", prod_s(0), 32'd100);
    check("t6.acc",  acc_s(0),  32'd0);
    check("t6.ovf",  {31'd0, ovf_s(0)},  32'd0);
    check("t6.busy", {31'd0, busy_s(0)}, 32'd0);
    tick();
    check("t6.done_drop", {31'd0, done_s(0)}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
